mor1kx_pic_vec: RTL

Parametrised programmable interrupt controller for the mor1kx SPR group 9. It supports 1–32 interrupt lines, each with its own trigger mode (level, latched level, or edge), and a configurable count of non-maskable low lines. It adds a registered priority encoder that reports the highest-priority pending line and its ID, plus an acknowledge handshake that clears that line. It sits between the external IRQ wires and the CPU exception logic, on the SPR bus like the existing PIC.

---
 rtl/mor1kx_pic_vec_if.sv | 19 +
 rtl/mor1kx_pic_vec.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mor1kx_pic_vec_if.sv
// SPR bus bundle between the CPU SPR decoder (master) and the vectored PIC (slave).
interface mor1kx_pic_vec_if;
  logic        spr_access_i;
  logic        spr_we_i;
  logic [15:0] spr_addr_i;
  logic [31:0] spr_dat_i;
  logic        spr_bus_ack;
  logic [31:0] spr_dat_o;

  modport master (
    output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    input  spr_bus_ack, spr_dat_o
  );

  modport slave (
    input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
    output spr_bus_ack, spr_dat_o
  );
endinterface

// File: rtl/mor1kx_pic_vec.sv
// Programmable interrupt controller (SPR group 9) with per-line level/latched/edge
// trigger modes, NMI lines and a registered lowest-index priority encoder with ack.
module mor1kx_pic_vec #(
  parameter int          NUM_IRQ              = 32,
  parameter int          OPTION_PIC_NMI_WIDTH = 0,
  parameter logic [31:0] EDGE_LINES           = 32'h0,
  parameter logic [31:0] LATCH_LINES          = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               irq_ack_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  output logic [31:0]        spr_picmr_o,
  output logic [31:0]        spr_picsr_o,
  mor1kx_pic_vec_if.slave    spr
);

  function automatic logic [31:0] low_ones(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] first_set(input logic [31:0] v);
    logic [4:0] id;
    id = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) id = 5'(i);
    return id;
  endfunction

  localparam logic [31:0] VALID    = low_ones(NUM_IRQ);
  localparam logic [31:0] NMI_MASK = low_ones(OPTION_PIC_NMI_WIDTH) & VALID;
  localparam logic [31:0] EDGE_M   = EDGE_LINES & VALID;
  localparam logic [31:0] LATCH_M  = LATCH_LINES & ~EDGE_LINES & VALID;
  localparam logic [31:0] STICKY_M = EDGE_M | LATCH_M;
  localparam logic [31:0] LEVEL_M  = VALID & ~STICKY_M;

  localparam logic [10:0] OFF_PICMR = 11'd0;
  localparam logic [10:0] OFF_PICSR = 11'd2;
  localparam logic [10:0] OFF_PICID = 11'd3;

  logic [31:0] picmr_p1;
  logic [31:0] pend_p1;
  logic [31:0] unmasked_p1;
  logic        irq_p2;
  logic [4:0]  irq_id_p2;

  logic [31:0] irq_ext;
  logic [31:0] unmasked;
  logic [31:0] picsr;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] pend_next;
  logic [10:0] offset;
  logic        wr_picmr;
  logic        wr_picsr;
  logic        addr_unused;

  // Stage 0: masking, set/clear decode and the architecturally visible PICSR
  always_comb begin
    irq_ext   = 32'(irq_i);
    unmasked  = picmr_p1 & irq_ext;
    picsr     = (pend_p1 & STICKY_M) | (unmasked & LEVEL_M);
    offset    = spr.spr_addr_i[10:0];
    wr_picmr  = spr.spr_access_i & spr.spr_we_i & (offset == OFF_PICMR);
    wr_picsr  = spr.spr_access_i & spr.spr_we_i & (offset == OFF_PICSR);
    set_vec   = (unmasked & LATCH_M) | (unmasked & ~unmasked_p1 & EDGE_M);
    clr_vec   = '0;
    if (wr_picsr)
      clr_vec = spr.spr_dat_i;
    // Only a real pending report can be acknowledged
    if (irq_ack_i && irq_p2)
      clr_vec = clr_vec | (32'd1 << irq_id_p2);
    pend_next = ((pend_p1 & ~clr_vec) | set_vec) & STICKY_M;
  end

  assign addr_unused = ^spr.spr_addr_i[15:11];

  // Stage 1: mask, pending and edge-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      picmr_p1    <= NMI_MASK;
      pend_p1     <= '0;
      unmasked_p1 <= '0;
    end else begin
      if (wr_picmr)
        picmr_p1 <= (spr.spr_dat_i | NMI_MASK) & VALID;
      pend_p1     <= pend_next;
      unmasked_p1 <= unmasked;
    end
  end

  // Stage 2: registered priority encoder; the ID holds while nothing is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_p2    <= 1'b0;
      irq_id_p2 <= '0;
    end else begin
      irq_p2 <= |picsr;
      if (|picsr)
        irq_id_p2 <= first_set(picsr);
    end
  end

  always_comb begin
    spr.spr_dat_o = '0;
    case (offset)
      OFF_PICMR: spr.spr_dat_o = picmr_p1;
      OFF_PICSR: spr.spr_dat_o = picsr;
      OFF_PICID: spr.spr_dat_o = {26'b0, irq_p2, irq_id_p2};
      default:   spr.spr_dat_o = '0;
    endcase
  end

  assign spr.spr_bus_ack = spr.spr_access_i;
  assign spr_picmr_o     = picmr_p1;
  assign spr_picsr_o     = picsr;
  assign irq_o           = irq_p2;
  assign irq_id_o        = irq_id_p2;

endmodule
